pu_riscv_alu_pipe: RTL

- Parametrised successor to the single-cycle execute ALU.
- Computes RV32I/RV64I integer and CSR-read results through STAGES register stages.
- Uses valid/ready handshakes on both sides, a pipeline flush, and legal/illegal tagging per op.
- Sits in the execute stage between operand select and write-back, which gives timing closure at wide XLEN.

---
 rtl/pu_riscv_alu_pipe_pkg.sv | 52 +++++
 rtl/pu_riscv_alu_pipe_if.sv | 33 +++
 rtl/pu_riscv_alu_core.sv | 172 +++++++++++++++++
 rtl/pu_riscv_alu_pipe.sv | 109 ++++++++++
 4 files changed

// File: rtl/pu_riscv_alu_pipe_pkg.sv
// Shared definitions for the pipelined execute ALU: major opcodes, func
// patterns, the XLEN mode encoding and the pipeline stage record.
// Optional Zba decode is controlled by the macro PU_RISCV_ALU_ZBA_EN.
package pu_riscv_verilog_pkg;

  // Major opcodes, instr[6:2]; bits 1:0 only distinguish compressed ops
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_SH1ADD = 3'b010;
  localparam logic [2:0] F3_SH2ADD = 3'b100;
  localparam logic [2:0] F3_SH3ADD = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ZBA  = 7'b0010000;

  // misa.MXL style mode encoding
  localparam logic [1:0] XLEN_RV32I = 2'b01;
  localparam logic [1:0] XLEN_RV64I = 2'b10;

  // Stage record sized for the widest datapath; narrower builds use r[XLEN-1:0]
  localparam int unsigned ALU_XLEN_MAX = 64;

  typedef struct packed {
    logic                    valid;
    logic                    bubble;
    logic [ALU_XLEN_MAX-1:0] r;
  } alu_stage_t;

  // Sign-extend a 32-bit W-op result to 64 bits
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/pu_riscv_alu_pipe_if.sv
// Handshake and operand bundle between operand select, the ALU pipe and
// write-back. slave = ALU pipe side, master = surrounding pipeline side.
interface pu_riscv_alu_pipe_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] id_pc;
  logic            id_bubble;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [1:0]      st_xlen;
  logic [XLEN-1:0] st_csr_rval;
  logic            ex_flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_r;
  logic            alu_bubble;

  modport slave (
    input  in_valid, id_pc, id_bubble, id_instr, opA, opB, st_xlen,
           st_csr_rval, ex_flush, out_ready,
    output in_ready, out_valid, alu_r, alu_bubble
  );

  modport master (
    output in_valid, id_pc, id_bubble, id_instr, opA, opB, st_xlen,
           st_csr_rval, ex_flush, out_ready,
    input  in_ready, out_valid, alu_r, alu_bubble
  );
endinterface

// File: rtl/pu_riscv_alu_core.sv
// Combinational decode and compute for the execute ALU. Produces {legal, r};
// r is forced to zero for anything not decoded as legal.
// Zba shift-add ops are decoded only when PU_RISCV_ALU_ZBA_EN is defined.
module pu_riscv_alu_core
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int HAS_RVC = 1
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  input  logic [XLEN-1:0] csr_rval,
  output logic            legal,
  output logic [XLEN-1:0] r
);

  logic [4:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            is_rvc;
  logic            mode32;
  logic            w_ok;
  logic [5:0]      shamt;
  logic [4:0]      shamt_w;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] res;
  logic [31:0]     w_res;
  logic [63:0]     w_ext;
  logic            use_w;

  // Register/immediate select bits are resolved upstream into opA/opB
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  assign opc     = instr[6:2];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign is_rvc  = (instr[1:0] != 2'b11);
  assign mode32  = (XLEN == 32) || (st_xlen == XLEN_RV32I);
  assign w_ok    = (XLEN == 64) && (st_xlen != XLEN_RV32I);
  assign shamt   = mode32 ? {1'b0, opB[4:0]} : opB[5:0];
  assign shamt_w = opB[4:0];
  assign link    = pc + ((HAS_RVC != 0 && is_rvc) ? XLEN'(2) : XLEN'(4));
  assign w_ext   = sext32(w_res);

  // Decode and compute; every path assigns legal/res so nothing latches
  always_comb begin
    legal = 1'b0;
    res   = '0;
    w_res = '0;
    use_w = 1'b0;
    // Compressed ops arrive expanded but keep their low two bits
    if (HAS_RVC != 0 || !is_rvc) begin
      case (opc)
        OPC_LUI, OPC_AUIPC: begin
          legal = 1'b1;
          res   = opA + opB;
        end
        OPC_JAL: begin
          legal = 1'b1;
          res   = link;
        end
        OPC_JALR: begin
          legal = (f3 == 3'b000);
          res   = link;
        end
        OPC_OP_IMM: begin
          case (f3)
            F3_ADD:  begin legal = 1'b1; res = opA + opB; end
            F3_SLT:  begin legal = 1'b1; res = XLEN'($signed(opA) < $signed(opB)); end
            F3_SLTU: begin legal = 1'b1; res = XLEN'(opA < opB); end
            F3_XOR:  begin legal = 1'b1; res = opA ^ opB; end
            F3_OR:   begin legal = 1'b1; res = opA | opB; end
            F3_AND:  begin legal = 1'b1; res = opA & opB; end
            F3_SLL: begin
              // shamt[5] lives in f7[0] and is illegal in 32-bit mode
              legal = (f7[6:1] == 6'b000000) && !(mode32 && f7[0]);
              res   = opA << shamt;
            end
            default: begin // F3_SR
              legal = (f7[6:1] == 6'b000000 || f7[6:1] == 6'b010000) &&
                      !(mode32 && f7[0]);
              res   = f7[5] ? XLEN'($signed(opA) >>> shamt) : (opA >> shamt);
            end
          endcase
        end
        OPC_OP: begin
          if (f7 == F7_BASE) begin
            legal = 1'b1;
            case (f3)
              F3_ADD:  res = opA + opB;
              F3_SLL:  res = opA << shamt;
              F3_SLT:  res = XLEN'($signed(opA) < $signed(opB));
              F3_SLTU: res = XLEN'(opA < opB);
              F3_XOR:  res = opA ^ opB;
              F3_SR:   res = opA >> shamt;
              F3_OR:   res = opA | opB;
              default: res = opA & opB;
            endcase
          end else if (f7 == F7_ALT) begin
            if (f3 == F3_ADD) begin
              legal = 1'b1;
              res   = opA - opB;
            end else if (f3 == F3_SR) begin
              legal = 1'b1;
              res   = XLEN'($signed(opA) >>> shamt);
            end
          end
`ifdef PU_RISCV_ALU_ZBA_EN
          else if (f7 == F7_ZBA) begin
            case (f3)
              F3_SH1ADD: begin legal = 1'b1; res = (opA << 1) + opB; end
              F3_SH2ADD: begin legal = 1'b1; res = (opA << 2) + opB; end
              F3_SH3ADD: begin legal = 1'b1; res = (opA << 3) + opB; end
              default:   begin legal = 1'b0; res = '0; end
            endcase
          end
`endif
        end
        OPC_OP_IMM_32: begin
          use_w = 1'b1;
          case (f3)
            F3_ADD: begin
              legal = w_ok;
              w_res = opA[31:0] + opB[31:0];
            end
            F3_SLL: begin
              legal = w_ok && (f7 == F7_BASE);
              w_res = opA[31:0] << shamt_w;
            end
            F3_SR: begin
              legal = w_ok && (f7 == F7_BASE || f7 == F7_ALT);
              w_res = f7[5] ? 32'($signed(opA[31:0]) >>> shamt_w) : (opA[31:0] >> shamt_w);
            end
            default: legal = 1'b0;
          endcase
        end
        OPC_OP_32: begin
          use_w = 1'b1;
          if (f7 == F7_BASE) begin
            case (f3)
              F3_ADD:  begin legal = w_ok; w_res = opA[31:0] + opB[31:0]; end
              F3_SLL:  begin legal = w_ok; w_res = opA[31:0] << shamt_w; end
              F3_SR:   begin legal = w_ok; w_res = opA[31:0] >> shamt_w; end
              default: legal = 1'b0;
            endcase
          end else if (f7 == F7_ALT) begin
            case (f3)
              F3_ADD:  begin legal = w_ok; w_res = opA[31:0] - opB[31:0]; end
              F3_SR:   begin legal = w_ok; w_res = 32'($signed(opA[31:0]) >>> shamt_w); end
              default: legal = 1'b0;
            endcase
          end
        end
        OPC_SYSTEM: begin
          // funct3 000 (ECALL/EBREAK/xRET) and 100 are not CSR accesses
          legal = (f3 != 3'b000) && (f3 != 3'b100);
          res   = csr_rval;
        end
        default: legal = 1'b0;
      endcase
    end
    if (use_w) begin
      res = w_ext[XLEN-1:0];
    end
    r = legal ? res : '0;
  end

endmodule

// File: rtl/pu_riscv_alu_pipe.sv
// Pipelined execute ALU: one compute stage followed by STAGES-1 carry
// stages (STAGES legal range 1..4), valid/ready on both sides, flush.
// Empty stages collapse, so in_ready is combinational from out_ready.
// Optional Zba support: define PU_RISCV_ALU_ZBA_EN.
module pu_riscv_alu_pipe
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ILEN    = 64,
  parameter int STAGES  = 2,
  parameter int HAS_RVC = 1
) (
  input logic               clk,
  input logic               rst,
  pu_riscv_alu_pipe_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  logic            core_legal;
  logic [XLEN-1:0] core_r;
  alu_stage_t      stage_in;
  alu_stage_t      stage_reg [STAGES];
  alu_stage_t      stage_src [STAGES];
  logic [STAGES-1:0] stage_ready;

  pu_riscv_alu_core #(
    .XLEN    (XLEN),
    .HAS_RVC (HAS_RVC)
  ) u_core (
    .pc       (bus.id_pc),
    .instr    (bus.id_instr[31:0]),
    .opA      (bus.opA),
    .opB      (bus.opB),
    .st_xlen  (bus.st_xlen),
    .csr_rval (bus.st_csr_rval),
    .legal    (core_legal),
    .r        (core_r)
  );

  if (ILEN > 32) begin : g_instr_hi
    logic unused_instr_hi;
    assign unused_instr_hi = ^bus.id_instr[ILEN-1:32];
  end

  // New stage-0 record: bubbles and illegal ops carry a zero result
  always_comb begin
    stage_in        = '0;
    stage_in.valid  = bus.in_valid;
    stage_in.bubble = bus.id_bubble || !core_legal;
    if (!stage_in.bubble) begin
      stage_in.r[XLEN-1:0] = core_r;
    end
  end

  // Source for each stage: stage 0 takes the new op, others the stage before
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
    if (gi == 0) begin : g_first
      assign stage_src[gi] = stage_in;
    end else begin : g_carry
      assign stage_src[gi] = stage_reg[gi-1];
    end
  end

  // Stage k may load when it, or any stage after it, is empty, or the
  // output is being taken; flat form avoids a comb loop through the chain
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_ready[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!stage_reg[j].valid) begin
          stage_ready[k] = 1'b1;
        end
      end
    end
  end

  // Stage registers: reset, then flush (drops valids only), then advance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_reg[k].valid  <= 1'b0;
        stage_reg[k].bubble <= 1'b1;
        stage_reg[k].r      <= '0;
      end
    end else if (bus.ex_flush) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_reg[k].valid <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          stage_reg[k].valid <= stage_src[k].valid;
          // Data only moves with a real op so held values stay meaningful
          if (stage_src[k].valid) begin
            stage_reg[k].bubble <= stage_src[k].bubble;
            stage_reg[k].r      <= stage_src[k].r;
          end
        end
      end
    end
  end

  assign bus.in_ready   = stage_ready[0];
  assign bus.out_valid  = stage_reg[LAST].valid;
  assign bus.alu_r      = stage_reg[LAST].r[XLEN-1:0];
  assign bus.alu_bubble = stage_reg[LAST].bubble;

endmodule
